cue_player: RTL

CUE_PLAYER -- requirements
Module: cue_player

---
 rtl/cue_player.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cue_player.sv
// cue_player -- plays one of three short buzzer cues for the game controller.
//
// A rising edge on st_i while idle latches sel_i and starts a four-slot cue.
// Each slot lasts SLOT_CYC clocks and is either a square-wave tone or a rest.
// busy_o is high while the cue plays. over_o pulses for one cycle when the
// cue finishes. Selecting cue 3 produces only the over_o pulse, with no sound.
//
// Ports:
//   clk_i    system clock, all state on the rising edge
//   rst_ni   asynchronous active-low reset
//   st_i     start request level; a rising edge triggers playback
//   sel_i    cue select: 0 success, 1 fail, 2 victory, 3 silent
//   abort_i  synchronous stop of a playing cue (no over_o pulse)
//   beep_o   square-wave buzzer drive
//   busy_o   high while a cue is playing
//   over_o   one-cycle completion pulse
module cue_player #(
  parameter int SLOT_CYC = 125000,
  parameter int HALF_C5  = 956,
  parameter int HALF_E5  = 758,
  parameter int HALF_G5  = 638,
  parameter int HALF_C6  = 478,
  parameter int HALF_BUZ = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       st_i,
  input  logic [1:0] sel_i,
  input  logic       abort_i,
  output logic       beep_o,
  output logic       busy_o,
  output logic       over_o
);

  // Largest half-period sets the tone counter width. The counter only
  // holds values up to HALF-1, so the ROM stores HALF-1 directly.
  localparam int MAX_A    = (HALF_C5 > HALF_E5) ? HALF_C5 : HALF_E5;
  localparam int MAX_B    = (HALF_G5 > HALF_C6) ? HALF_G5 : HALF_C6;
  localparam int MAX_AB   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int HALF_MAX = (MAX_AB > HALF_BUZ) ? MAX_AB : HALF_BUZ;
  localparam int TONE_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int CYC_W    = $clog2(SLOT_CYC);

  localparam logic [CYC_W-1:0]  SLOT_LAST = CYC_W'(SLOT_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
  localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
  localparam logic [TONE_W-1:0] M1_C5     = TONE_W'(HALF_C5 - 1);
  localparam logic [TONE_W-1:0] M1_E5     = TONE_W'(HALF_E5 - 1);
  localparam logic [TONE_W-1:0] M1_G5     = TONE_W'(HALF_G5 - 1);
  localparam logic [TONE_W-1:0] M1_C6     = TONE_W'(HALF_C6 - 1);
  localparam logic [TONE_W-1:0] M1_BUZ    = TONE_W'(HALF_BUZ - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  state_e            state_q, state_d;
  logic              stPrev_q, stPrev_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        slot_q, slot_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              beep_q, beep_d;

  logic              trigger;
  logic              toneOn;
  logic [TONE_W-1:0] halfM1;

  // Cue ROM: for the latched cue and current slot, say whether the slot
  // sounds and give its half-period minus one.
  always_comb begin
    toneOn = 1'b1;
    halfM1 = '0;
    unique case (sel_q)
      2'd0: begin
        unique case (slot_q)
          2'd0:    halfM1 = M1_C5;
          2'd1:    halfM1 = M1_G5;
          default: toneOn = 1'b0;
        endcase
      end
      2'd1: begin
        if (slot_q == 2'd3) toneOn = 1'b0;
        else                halfM1 = M1_BUZ;
      end
      2'd2: begin
        unique case (slot_q)
          2'd0:    halfM1 = M1_C5;
          2'd1:    halfM1 = M1_E5;
          2'd2:    halfM1 = M1_G5;
          default: halfM1 = M1_C6;
        endcase
      end
      default: toneOn = 1'b0;
    endcase
  end

  // Next-state logic. Triggers are only looked at in IDLE, so start edges
  // during playback are simply dropped. Every slot boundary restarts the
  // tone counter with beep low so each tone's first rise lands HALF cycles
  // into its slot.
  always_comb begin
    state_d  = state_q;
    stPrev_d = st_i;
    sel_d    = sel_q;
    slot_d   = slot_q;
    cyc_d    = cyc_q;
    tone_d   = tone_q;
    beep_d   = beep_q;
    trigger  = st_i & ~stPrev_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          sel_d   = sel_i;
          slot_d  = 2'd0;
          cyc_d   = '0;
          tone_d  = '0;
          beep_d  = 1'b0;
          state_d = (sel_i == 2'd3) ? DONE : PLAY;
        end
      end
      PLAY: begin
        if (abort_i) begin
          state_d = IDLE;
          slot_d  = 2'd0;
          cyc_d   = '0;
          tone_d  = '0;
          beep_d  = 1'b0;
        end else if (cyc_q == SLOT_LAST) begin
          cyc_d  = '0;
          tone_d = '0;
          beep_d = 1'b0;
          if (slot_q == 2'd3) begin
            slot_d  = 2'd0;
            state_d = DONE;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
          if (toneOn) begin
            if (tone_q == halfM1) begin
              tone_d = '0;
              beep_d = ~beep_q;
            end else begin
              tone_d = tone_q + TONE_ONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset clears st history too, so a start level already
  // high when reset releases counts as a fresh edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      stPrev_q <= 1'b0;
      sel_q    <= 2'd0;
      slot_q   <= 2'd0;
      cyc_q    <= '0;
      tone_q   <= '0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stPrev_q <= stPrev_d;
      sel_q    <= sel_d;
      slot_q   <= slot_d;
      cyc_q    <= cyc_d;
      tone_q   <= tone_d;
      beep_q   <= beep_d;
    end
  end

  assign beep_o = beep_q;
  assign busy_o = (state_q == PLAY);
  assign over_o = (state_q == DONE);

endmodule
